axis_testpattern_checker: RTL

AXI4-Stream slave that consumes the counter test pattern produced by the team's AXIS test-pattern generator and verifies it beat by beat. It locks onto the sequence, counts accepted beats and sequence errors, and reports lock state for the bench or for ILA/status registers. It sits at the far end of any stream path under test (FIFO, DMA loop, interconnect). An optional built-in tready throttle exercises upstream backpressure.

---
 rtl/axis_testpattern_pkg.sv | 21 ++
 rtl/axis_ready_throttle.sv | 25 ++
 rtl/axis_testpattern_checker.sv | 105 ++++++++++
 3 files changed

// File: rtl/axis_testpattern_pkg.sv
// Shared definitions for the AXIS counter test pattern: wrap rule and checker FSM encodings.
// The generator and the checker both call next_value() so they wrap identically.
package axis_testpattern_pkg;

  localparam logic [0:0] ST_HUNT   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // Operates on 64-bit containers; the result is reduced modulo 2^width (width <= 64).
  function automatic logic [63:0] next_value(
    input logic [63:0] x,
    input logic [63:0] start,
    input logic [63:0] last,
    input logic [63:0] incr,
    input int unsigned width
  );
    logic [63:0] mask;
    mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (x >= last) ? (start & mask) : ((x + incr) & mask);
  endfunction

endpackage

// File: rtl/axis_ready_throttle.sv
// Free-running tready throttle: registered ready high one cycle in every READY_PERIOD.
module axis_ready_throttle #(
  parameter int unsigned READY_PERIOD = 1
) (
  input  logic clk,
  input  logic rst,
  output logic ready
);

  localparam int unsigned CNT_W = (READY_PERIOD > 1) ? $clog2(READY_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READY_PERIOD - 1);

  logic [CNT_W-1:0] ready_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_cnt <= '0;
      ready     <= 1'b0;
    end else begin
      ready_cnt <= (ready_cnt == CNT_LAST) ? '0 : ready_cnt + CNT_W'(1);
      ready     <= (READY_PERIOD == 1) || (ready_cnt == CNT_LAST);
    end
  end

endmodule

// File: rtl/axis_testpattern_checker.sv
// AXI4-Stream sink that locks onto the counter test pattern and counts beats and sequence errors.
module axis_testpattern_checker
  import axis_testpattern_pkg::*;
#(
  parameter int unsigned S00_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned COUNTER_START        = 1,
  parameter int unsigned COUNTER_END          = 5,
  parameter int unsigned COUNTER_INCR         = 1,
  parameter int unsigned READY_PERIOD         = 1,
  parameter int unsigned LOCK_LOSS            = 4
) (
  input  logic                            s_axis_aclk,
  input  logic                            s_axis_areset,
  input  logic [S00_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            clear,
  output logic                            locked,
  output logic                            error_pulse,
  output logic                            error_sticky,
  output logic [31:0]                     error_count,
  output logic [31:0]                     beat_count,
  output logic [S00_AXIS_TDATA_WIDTH-1:0] last_bad_data,
  output logic [S00_AXIS_TDATA_WIDTH-1:0] last_expected
);

  localparam int unsigned W     = S00_AXIS_TDATA_WIDTH;
  localparam int unsigned RUN_W = $clog2(LOCK_LOSS + 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LOCK_LOSS - 1);
  localparam logic [W-1:0] START_W = W'(COUNTER_START);

  logic [0:0]       state;
  logic [W-1:0]     expected;
  logic [RUN_W-1:0] run_cnt;
  logic             accept;
  logic [W-1:0]     next_of_beat;
  logic [W-1:0]     next_of_start;

  axis_ready_throttle #(.READY_PERIOD(READY_PERIOD)) u_throttle (
    .clk   (s_axis_aclk),
    .rst   (s_axis_areset),
    .ready (s_axis_tready)
  );

  assign accept        = s_axis_tvalid && s_axis_tready;
  assign locked        = (state == ST_LOCKED);
  assign next_of_beat  = W'(next_value(64'(s_axis_tdata), 64'(COUNTER_START), 64'(COUNTER_END),
                                       64'(COUNTER_INCR), W));
  assign next_of_start = W'(next_value(64'(COUNTER_START), 64'(COUNTER_START), 64'(COUNTER_END),
                                       64'(COUNTER_INCR), W));

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      state         <= ST_HUNT;
      expected      <= '0;
      run_cnt       <= '0;
      error_pulse   <= 1'b0;
      error_sticky  <= 1'b0;
      error_count   <= '0;
      beat_count    <= '0;
      last_bad_data <= '0;
      last_expected <= '0;
    end else begin
      error_pulse <= 1'b0;
      // clear wins over a coincident beat: the beat is consumed but leaves no trace
      if (clear) begin
        state         <= ST_HUNT;
        expected      <= '0;
        run_cnt       <= '0;
        error_sticky  <= 1'b0;
        error_count   <= '0;
        beat_count    <= '0;
        last_bad_data <= '0;
        last_expected <= '0;
      end else if (accept) begin
        beat_count <= beat_count + 32'd1;
        if (state == ST_HUNT) begin
          if (s_axis_tdata == START_W) begin
            state    <= ST_LOCKED;
            expected <= next_of_start;
            run_cnt  <= '0;
          end
        end else begin
          expected <= next_of_beat;
          if (s_axis_tdata == expected) begin
            run_cnt <= '0;
          end else begin
            error_pulse   <= 1'b1;
            error_sticky  <= 1'b1;
            last_bad_data <= s_axis_tdata;
            last_expected <= expected;
            if (error_count != '1) error_count <= error_count + 32'd1;
            if (run_cnt == RUN_LAST) begin
              state   <= ST_HUNT;
              run_cnt <= '0;
            end else begin
              run_cnt <= run_cnt + RUN_W'(1);
            end
          end
        end
      end
    end
  end

endmodule
